// File: rtl/adder_pkg.sv
// Shared definitions for the registered ripple-carry adder.
// Holds the default datapath width and a plain-arithmetic golden add
// function that benches can use as a reference.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Returns {carry, sum}: bit 32 is the carry out of bit (width-1), and
  // bits [31:0] hold the sum truncated to 'width' bits (legal 1..32).
  function automatic logic [32:0] ref_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        cin,
                                          input int unsigned width);
    logic [32:0] full;
    logic [32:0] mask;
    full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    mask = (33'd1 << width) - 33'd1;
    return {full[width], full[31:0] & mask[31:0]};
  endfunction

endpackage

// File: rtl/adder_4bit_if.sv
// Operand/result bundle of the adder. The master drives operands and the
// input qualifier; the slave (the adder) returns the registered results.
// Optional macro ADDER_4BIT_OVF_EN adds the signed-overflow flag ovf.
interface adder_4bit_if #(
  parameter int WIDTH = adder_pkg::DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_input;
  logic [WIDTH-1:0] s;
  logic             c_output;
  logic             out_valid;
`ifdef ADDER_4BIT_OVF_EN
  logic             ovf;

  modport master (output in_valid, a, b, c_input,
                  input  s, c_output, out_valid, ovf);
  modport slave  (input  in_valid, a, b, c_input,
                  output s, c_output, out_valid, ovf);
`else
  modport master (output in_valid, a, b, c_input,
                  input  s, c_output, out_valid);
  modport slave  (input  in_valid, a, b, c_input,
                  output s, c_output, out_valid);
`endif

endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder cell; chained WIDTH times to form the ripple carry.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // Propagate term shared by the sum and the carry generate/propagate path.
  always_comb begin
    p    = a ^ b;
    s    = p ^ cin;
    cout = (a & b) | (cin & p);
  end

endmodule

// File: rtl/adder_4bit.sv
// Registered ripple-carry adder: {c_output, s} = a + b + c_input, one-cycle
// latency, outputs hold between accepted inputs.
// Optional macro ADDER_4BIT_OVF_EN adds a registered two's-complement
// overflow flag (carry into MSB XOR carry out of MSB).
module adder_4bit
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic        clk,
  input logic        rst,
  adder_4bit_if.slave bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = bus.c_input;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_cell u_fa (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             vld_q, vld_d;

  // Capture a new result only on accepted inputs; otherwise hold, so idle
  // operand values (including X/Z) never reach the outputs.
  always_comb begin
    s_d   = s_q;
    c_d   = c_q;
    vld_d = bus.in_valid;
    if (bus.in_valid) begin
      s_d = sum;
      c_d = carry[WIDTH];
    end
  end

  // Output registers; reset wins over a same-cycle valid input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '0;
      c_q   <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      c_q   <= c_d;
      vld_q <= vld_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.c_output  = c_q;
  assign bus.out_valid = vld_q;

`ifdef ADDER_4BIT_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: the carries into and out of the sign bit disagree.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.in_valid) begin
      ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  // Overflow flag register, same timing and reset as the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_4bit.sv
// Scoreboard bench for adder_4bit: the driver pushes expected results,
// a negedge monitor pops and compares whenever out_valid is high and
// checks hold/reset behaviour otherwise.
module tb_adder_4bit;

  localparam int W = 4;

  typedef struct {
    int s;
    int c;
    int ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen = 1'b1;

  exp_t q[$];
  exp_t hold;
  int   n_chk  = 0;
  int   n_fail = 0;

  adder_4bit_if #(.WIDTH(W)) bus ();

  adder_4bit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: unsigned sum for s/c, signed range test for ovf.
  function automatic exp_t model(input int a, input int b, input int cin);
    exp_t e;
    int   tot, sa, sb, ssum;
    tot  = a + b + cin;
    e.s  = tot % (1 << W);
    e.c  = tot / (1 << W);
    sa   = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb   = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    ssum = sa + sb + cin;
    e.ov = (ssum > (1 << (W - 1)) - 1 || ssum < -(1 << (W - 1))) ? 1 : 0;
    return e;
  endfunction

  task automatic drive(input bit v, input int a, input int b, input int cin,
                       input bit r);
    rst          = r;
    bus.in_valid = v;
    bus.a        = a[W-1:0];
    bus.b        = b[W-1:0];
    bus.c_input  = cin[0];
    if (v && !r) q.push_back(model(a, b, cin));
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) rst_seen <= rst;

  // Monitor: compare outputs after each active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      chk("rst_s", int'(bus.s), 0);
      chk("rst_c", int'(bus.c_output), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
`ifdef ADDER_4BIT_OVF_EN
      chk("rst_ovf", int'(bus.ovf), 0);
`endif
      hold = '{0, 0, 0};
    end else if (bus.out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("sum", int'(bus.s), e.s);
        chk("carry", int'(bus.c_output), e.c);
`ifdef ADDER_4BIT_OVF_EN
        chk("ovf", int'(bus.ovf), e.ov);
`endif
        hold = e;
      end
    end else begin
      chk("hold_s", int'(bus.s), hold.s);
      chk("hold_c", int'(bus.c_output), hold.c);
`ifdef ADDER_4BIT_OVF_EN
      chk("hold_ovf", int'(bus.ovf), hold.ov);
`endif
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.c_input  = 1'b0;

    // Reset held with a live input pending
    drive(1, 4'hF, 4'hF, 1, 1);
    drive(1, 4'hF, 4'hF, 1, 1);

    // Directed cases
    drive(1, 4'b1011, 4'b0100, 0, 0);
    drive(1, 4'b0111, 4'b1101, 1, 0);
    drive(1, 4'b0000, 4'b0000, 0, 0);
    drive(1, 4'b1111, 4'b0000, 1, 0);
    drive(1, 4'b1111, 4'b1111, 1, 0);
    drive(0, 0, 0, 0, 0);

    // Streaming then idle with moving operands
    drive(1, 3, 5, 0, 0);
    drive(1, 9, 9, 1, 0);
    drive(1, 14, 2, 1, 0);
    drive(0, 6, 11, 1, 0);
    drive(0, 13, 4, 0, 0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = 'x;
    bus.b        = 'x;
    bus.c_input  = 1'bx;
    @(posedge clk);
    #1;

    // Reset mid-stream
    drive(1, 12, 7, 0, 0);
    drive(1, 5, 5, 1, 1);
    drive(0, 0, 0, 0, 0);

    // Signed overflow corners
    drive(1, 4'b0111, 4'b0001, 0, 0);
    drive(1, 4'b1000, 4'b1000, 0, 0);
    drive(1, 4'b1000, 4'b0111, 1, 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 99) < 75, int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 3);
    end

    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
